// File: rtl/abus_reg_slave_if.sv
// abus handshake/data bundle between abus_master and a register-bank target.
// The master modport drives request/op/address/write data; the slave modport answers.
interface abus_reg_slave_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  abus_req;
  logic                  abus_write;
  logic                  abus_read;
  logic                  abus_abort;
  logic [ADDR_WIDTH-1:0] abus_maddress;
  logic [DATA_WIDTH-1:0] abus_mwdata;
  logic                  abus_ack;
  logic [DATA_WIDTH-1:0] abus_srdata;
  logic                  abus_ssel;

  modport master (
    output abus_req, abus_write, abus_read, abus_abort, abus_maddress, abus_mwdata,
    input  abus_ack, abus_srdata, abus_ssel
  );

  modport slave (
    input  abus_req, abus_write, abus_read, abus_abort, abus_maddress, abus_mwdata,
    output abus_ack, abus_srdata, abus_ssel
  );
endinterface

// File: rtl/abus_reg_slave.sv
// abus register-bank target: NUM_REGS-1 R/W control registers plus a read-only status register.
// Optional ABUS_SLAVE_RDCLR_EN makes the status register sticky and clear-on-read.
module abus_reg_slave #(
  parameter int unsigned     ADDR_WIDTH  = 16,
  parameter int unsigned     DATA_WIDTH  = 16,
  parameter int unsigned     NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned     WAIT_CYCLES = 1
) (
  input  logic                           abus_clk,
  input  logic                           abus_rstb,
  abus_reg_slave_if.slave                bus,
  input  logic [DATA_WIDTH-1:0]          hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned TOP   = NUM_REGS - 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {OP_ABORT, OP_WRITE, OP_READ} op_t;

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic                  capture, exec;
  logic                  hit;
  op_t                   req_op, cap_op;
  logic [IDX_W-1:0]      cap_idx;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0] srdata_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rd_value;

  assign hit = (bus.abus_maddress[ADDR_WIDTH-1:IDX_W] == BASE_ADDR[ADDR_WIDTH-1:IDX_W]);

  always_comb begin
    req_op = OP_READ;
    if (bus.abus_abort)      req_op = OP_ABORT;
    else if (bus.abus_write) req_op = OP_WRITE;
  end

  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    exec    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.abus_req && hit && (bus.abus_abort || bus.abus_write || bus.abus_read)) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = bus.abus_abort ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.abus_req) begin
          state_d = S_IDLE;
        end else if (bus.abus_abort) begin
          state_d = S_ACK;
        end else if (cnt == '0) begin
          exec    = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_ACK: begin
        if (!bus.abus_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are latched once at capture; the bus may change freely afterwards.
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      cap_op    <= OP_ABORT;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (capture) begin
      cap_op    <= req_op;
      cap_idx   <= bus.abus_maddress[IDX_W-1:0];
      cap_wdata <= bus.abus_mwdata;
    end
  end

  for (genvar i = 0; i < TOP; i++) begin : g_ctrl
    logic [DATA_WIDTH-1:0] r;
    always_ff @(posedge abus_clk or negedge abus_rstb) begin
      if (!abus_rstb) begin
        r               <= '0;
        reg_wr_pulse[i] <= 1'b0;
      end else begin
        reg_wr_pulse[i] <= 1'b0;
        if (exec && cap_op == OP_WRITE && cap_idx == IDX_W'(i)) begin
          r               <= cap_wdata;
          reg_wr_pulse[i] <= 1'b1;
        end
      end
    end
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r;
  end

  // The status slot is never written from the bus, so its strobe stays low.
  assign reg_wr_pulse[TOP]                     = 1'b0;
  assign reg_q[TOP*DATA_WIDTH +: DATA_WIDTH]   = status_q;
  assign rd_value = reg_q[cap_idx*DATA_WIDTH +: DATA_WIDTH];

`ifdef ABUS_SLAVE_RDCLR_EN
  logic rd_clr;
  assign rd_clr = exec && (cap_op == OP_READ) && (cap_idx == IDX_W'(TOP));

  // OR-ing in hw_status after the clear lets a same-cycle set survive.
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) status_q <= '0;
    else            status_q <= (rd_clr ? '0 : status_q) | hw_status;
  end
`else
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) status_q <= '0;
    else            status_q <= hw_status;
  end
`endif

  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      ack_q    <= 1'b0;
      srdata_q <= '0;
    end else begin
      ack_q <= (state == S_ACK);
      if (exec && cap_op == OP_READ)                srdata_q <= rd_value;
      else if (state == S_ACK && state_d == S_IDLE) srdata_q <= '0;
    end
  end

  assign bus.abus_ack    = ack_q;
  assign bus.abus_srdata = srdata_q;
  assign bus.abus_ssel   = (state != S_IDLE);

endmodule

// File: tb/tb_abus_reg_slave.sv
// Randomized self-checking bench for abus_reg_slave against a transaction-level register model.
// Build with +define+ABUS_SLAVE_RDCLR_EN to also exercise the sticky clear-on-read status.
module tb_abus_reg_slave;

  localparam int unsigned WAIT = 1;
  localparam int OP_W = 0;
  localparam int OP_R = 1;
  localparam int OP_A = 2;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [15:0] hw_status = '0;
  logic [127:0] reg_q;
  logic [7:0]  reg_wr_pulse;

  abus_reg_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  abus_reg_slave #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .NUM_REGS   (8),
    .BASE_ADDR  (16'h0000),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .abus_clk    (clk),
    .abus_rstb   (rstb),
    .bus         (bus.slave),
    .hw_status   (hw_status),
    .reg_q       (reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents and expected status value.
  logic [15:0] m_regs [8];
  logic [15:0] m_status;

  int pulse_total = 0;
  int last_pulse_idx = -1;

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++)
      if (reg_wr_pulse[i]) begin
        pulse_total++;
        last_pulse_idx = i;
      end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] slot(input int i);
    return reg_q[i*16 +: 16];
  endfunction

  task automatic bus_idle();
    bus.abus_req   = 1'b0;
    bus.abus_write = 1'b0;
    bus.abus_read  = 1'b0;
    bus.abus_abort = 1'b0;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (i == 7) ? m_status : m_regs[i];
      check($sformatf("%s_reg%0d", tag, i), 32'(slot(i)), 32'(e));
    end
  endtask

  // One complete 4-phase transfer; returns read data seen while acked and ack latency
  // counted in falling edges after the request was driven (-1 if never acked).
  task automatic xfer(input logic [15:0] addr, input int op, input logic [15:0] wdata,
                      output logic [15:0] rdata, output int lat);
    @(negedge clk);
    bus.abus_maddress = addr;
    bus.abus_mwdata   = wdata;
    bus.abus_write    = (op == OP_W);
    bus.abus_read     = (op == OP_R);
    bus.abus_abort    = (op == OP_A);
    bus.abus_req      = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.abus_ack) begin
        lat = k;
        break;
      end
    end
    rdata = bus.abus_srdata;
    bus.abus_maddress = 16'($urandom);
    bus.abus_mwdata   = 16'($urandom);
    if (lat > 0) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        check("ack_hold", 32'(bus.abus_ack), 32'd1);
        check("rdata_hold", 32'(bus.abus_srdata), 32'(rdata));
      end
    end
    bus_idle();
    @(negedge clk);
    check("ack_tail", 32'(bus.abus_ack), 32'(lat > 0));
    check("srdata_clr", 32'(bus.abus_srdata), 32'd0);
    check("ssel_idle", 32'(bus.abus_ssel), 32'd0);
    @(negedge clk);
    check("ack_low", 32'(bus.abus_ack), 32'd0);
  endtask

  task automatic model_xfer(input string tag, input int idx, input int op, input logic [15:0] wdata);
    logic [15:0] rd;
    int lat;
    int p0;
    int exp_p;
    p0 = pulse_total;
    exp_p = 0;
    xfer(16'(idx), op, wdata, rd, lat);
    check({tag, "_lat"}, 32'(lat), (op == OP_A) ? 32'd2 : 32'(WAIT + 3));
    if (op == OP_R)
      check({tag, "_rdata"}, 32'(rd), 32'((idx == 7) ? m_status : m_regs[idx]));
    if (op == OP_W && idx != 7) begin
      m_regs[idx] = wdata;
      exp_p = 1;
    end
    check({tag, "_pulses"}, 32'(pulse_total - p0), 32'(exp_p));
    if (exp_p == 1) check({tag, "_pulse_idx"}, 32'(last_pulse_idx), 32'(idx));
`ifdef ABUS_SLAVE_RDCLR_EN
    if (op == OP_R && idx == 7) m_status = hw_status;
`endif
  endtask

  initial begin
    logic [15:0] rd;
    int lat;
    int p0;
    bus_idle();
    bus.abus_maddress = '0;
    bus.abus_mwdata   = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_status = '0;

    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("rst_ack", 32'(bus.abus_ack), 32'd0);
    check("rst_srdata", 32'(bus.abus_srdata), 32'd0);
    check("rst_ssel", 32'(bus.abus_ssel), 32'd0);
    check("rst_pulse", 32'(reg_wr_pulse), 32'd0);
    check_model("rst");

`ifndef ABUS_SLAVE_RDCLR_EN
    hw_status = 16'h1234;
    m_status  = 16'h1234;
`endif
    model_xfer("wr2", 2, OP_W, 16'hA5A5);
    check("wr2_slot", 32'(slot(2)), 32'h0000A5A5);
    model_xfer("rd2", 2, OP_R, 16'h0);
    model_xfer("wr7", 7, OP_W, 16'hFFFF);
    check_model("dir");

    // Out-of-window address must never be acked nor selected.
    @(negedge clk);
    bus.abus_maddress = 16'h0100;
    bus.abus_mwdata   = 16'hDEAD;
    bus.abus_write    = 1'b1;
    bus.abus_req      = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("miss_ack", 32'(bus.abus_ack), 32'd0);
      check("miss_ssel", 32'(bus.abus_ssel), 32'd0);
    end
    bus_idle();

    // Abort while waiting: ack follows, register untouched.
    p0 = pulse_total;
    @(negedge clk);
    bus.abus_maddress = 16'd3;
    bus.abus_mwdata   = 16'hBEEF;
    bus.abus_write    = 1'b1;
    bus.abus_req      = 1'b1;
    @(negedge clk);
    check("abw_ssel", 32'(bus.abus_ssel), 32'd1);
    bus.abus_abort = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abw_ack", 32'(bus.abus_ack), 32'd1);
    bus_idle();
    repeat (2) @(negedge clk);
    check("abw_noreg", 32'(slot(3)), 32'(m_regs[3]));
    check("abw_nopulse", 32'(pulse_total - p0), 32'd0);

    // Request withdrawn while waiting: access dropped, no ack.
    p0 = pulse_total;
    @(negedge clk);
    bus.abus_maddress = 16'd4;
    bus.abus_mwdata   = 16'hCAFE;
    bus.abus_write    = 1'b1;
    bus.abus_req      = 1'b1;
    @(negedge clk);
    bus_idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("drop_ack", 32'(bus.abus_ack), 32'd0);
    end
    check("drop_ssel", 32'(bus.abus_ssel), 32'd0);
    check("drop_noreg", 32'(slot(4)), 32'(m_regs[4]));
    check("drop_nopulse", 32'(pulse_total - p0), 32'd0);

    for (int n = 0; n < 60; n++) begin
      int r;
      int op;
      int idx;
      r   = int'($urandom_range(0, 9));
      op  = (r < 4) ? OP_W : (r < 8) ? OP_R : OP_A;
      idx = int'($urandom_range(0, 7));
`ifndef ABUS_SLAVE_RDCLR_EN
      @(negedge clk);
      hw_status = 16'($urandom);
      m_status  = hw_status;
`endif
      model_xfer($sformatf("rnd%0d", n), idx, op, 16'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

`ifdef ABUS_SLAVE_RDCLR_EN
    @(negedge clk);
    hw_status = 16'h0004;
    @(negedge clk);
    hw_status = 16'h0000;
    xfer(16'd7, OP_R, 16'h0, rd, lat);
    check("rdclr_first", 32'(rd), 32'h0004);
    xfer(16'd7, OP_R, 16'h0, rd, lat);
    check("rdclr_second", 32'(rd), 32'h0000);
    hw_status = 16'h0008;
    xfer(16'd7, OP_R, 16'h0, rd, lat);
    check("rdclr_set_a", 32'(rd), 32'h0008);
    xfer(16'd7, OP_R, 16'h0, rd, lat);
    check("rdclr_set_b", 32'(rd), 32'h0008);
    hw_status = 16'h0000;
    xfer(16'd7, OP_R, 16'h0, rd, lat);
    check("rdclr_set_c", 32'(rd), 32'h0008);
    xfer(16'd7, OP_R, 16'h0, rd, lat);
    check("rdclr_empty", 32'(rd), 32'h0000);
`endif

    // Asynchronous reset while acking clears everything without a clock edge.
    @(negedge clk);
    bus.abus_maddress = 16'd1;
    bus.abus_mwdata   = 16'h5A5A;
    bus.abus_write    = 1'b1;
    bus.abus_req      = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.abus_ack) begin
        lat = k;
        break;
      end
    end
    check("arst_pre_ack", 32'(lat), 32'(WAIT + 3));
    check("arst_pre_reg", 32'(slot(1)), 32'h00005A5A);
    #2 rstb = 1'b0;
    #1;
    check("arst_ack", 32'(bus.abus_ack), 32'd0);
    check("arst_ssel", 32'(bus.abus_ssel), 32'd0);
    check("arst_reg1", 32'(slot(1)), 32'd0);
    check("arst_reg2", 32'(slot(2)), 32'd0);
    bus_idle();
    hw_status = '0;
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_status = '0;
    @(negedge clk);
    check_model("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
